// File: rtl/sqrt_batch_engine.sv
// Batch integer square root: loads operands, then computes floor(sqrt) and remainder for entries 0..len-1.
// Latency WIDTH/2+2 cycles per word; writes and start requests are dropped while busy.
module sqrt_batch_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 st,
    input  logic [AW:0]          n_words,
    input  logic [AW-1:0]        rd_addr,
    output logic [WIDTH/2-1:0]   rd_root,
    output logic [WIDTH/2:0]     rd_rem,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        cur_addr,
    output logic [2:0]           state
);

    localparam int HW = WIDTH / 2;
    localparam int CW = (HW > 1) ? $clog2(HW) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CW-1:0] CNT_INIT = CW'(HW - 1);
    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_L    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [2:0]       r_state;
    logic [AW-1:0]    r_ptr;
    logic [AW:0]      r_len;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_op;
    logic [HW-1:0]    r_root;
    logic [HW:0]      r_rem;
    logic [HW-1:0]    r_rd_root;
    logic [HW:0]      r_rd_rem;

    logic [WIDTH-1:0] r_opmem  [DEPTH];
    logic [WIDTH:0]   r_resmem [DEPTH];

    logic [AW:0]      w_len_clamped;
    logic [HW+2:0]    w_rem_sh;
    logic [HW+2:0]    w_trial;
    logic             w_ge;
    logic [HW:0]      w_rem_nxt;
    logic [HW-1:0]    w_root_nxt;
    logic             w_last;
    logic             w_wr_ok;
    logic [WIDTH:0]   w_rd_word;

    assign w_len_clamped = (n_words > DEPTH_L) ? DEPTH_L : n_words;

    // One restoring step: bring down the next two operand bits, try subtracting (4*root + 1).
    assign w_rem_sh  = {r_rem, r_op[WIDTH-1 -: 2]};
    assign w_trial   = {1'b0, r_root, 2'b01};
    assign w_ge      = (w_rem_sh >= w_trial);
    // Remainder is bounded by 2*root, so the low HW+1 bits of the difference are exact.
    assign w_rem_nxt = w_ge ? (w_rem_sh[HW:0] - w_trial[HW:0]) : w_rem_sh[HW:0];

    generate
        if (HW > 1) begin : g_root_wide
            assign w_root_nxt = {r_root[HW-2:0], w_ge};
        end else begin : g_root_one
            assign w_root_nxt = w_ge;
        end
    endgenerate

    assign w_last    = ({1'b0, r_ptr} == (r_len - ONE_L));
    assign w_wr_ok   = wr_en && resetN && (r_state == S_IDLE) && ({1'b0, wr_addr} < DEPTH_L);
    assign w_rd_word = r_resmem[rd_addr];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_opmem[wr_addr] <= wr_data;
        end
        if (r_state == S_STORE) begin
            r_resmem[r_ptr] <= {r_rem, r_root};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_root    <= '0;
            r_rem     <= '0;
            r_rd_root <= '0;
            r_rd_rem  <= '0;
        end else begin
            r_rd_root <= w_rd_word[HW-1:0];
            r_rd_rem  <= w_rd_word[WIDTH:HW];
            case (r_state)
                S_IDLE: begin
                    if (st) begin
                        r_len <= w_len_clamped;
                        r_ptr <= '0;
                        r_state <= (w_len_clamped == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_op    <= r_opmem[r_ptr];
                    r_root  <= '0;
                    r_rem   <= '0;
                    r_cnt   <= CNT_INIT;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_op   <= r_op << 2;
                    r_root <= w_root_nxt;
                    r_rem  <= w_rem_nxt;
                    if (r_cnt == '0) begin
                        r_state <= S_STORE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_STORE: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_ptr   <= r_ptr + PTR_ONE;
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign cur_addr = r_ptr;
    assign state    = r_state;
    assign rd_root  = r_rd_root;
    assign rd_rem   = r_rd_rem;

endmodule
